alu_mdu: RTL
============

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (legal values 8..64, even).
REQ-002 SHALL have localparam SHW = $clog2(XLEN), meaning the shift-amount width.
REQ-003 SHALL have port clk  input  1  meaning the sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  meaning synchronous abort of any in-flight or held operation.
REQ-006 SHALL have port in_valid  input  1  meaning the operation request is valid.
REQ-007 SHALL have port in_ready  output  1  meaning the block can accept a request.
REQ-008 SHALL have port a  input  XLEN  meaning operand A.
REQ-009 SHALL have port b  input  XLEN  meaning operand B.
REQ-010 SHALL have port alu_op  input  5  meaning the operation code (REQ-015..017).
REQ-011 SHALL have port out_valid  output  1  meaning result, zero and err are valid.
REQ-012 SHALL have port out_ready  input  1  meaning the consumer takes the result.
REQ-013 SHALL have port result  output  XLEN  meaning the registered result.
REQ-014 SHALL have port zero  output  1 and port err  output  1, meaning result==0 and illegal opcode respectively.

Function
REQ-015 Single-pass opcodes SHALL be: 00000 AND, 00001 OR, 00010 ADD, 00110 SUB, 00111 SLT (signed), 00100 XOR, 00101 SLL, 01000 SRL, 01001 SRA, 01010 SLTU.
REQ-016 Shifts SHALL use b[SHW-1:0] only; ADD/SUB SHALL wrap modulo 2^XLEN; SLT/SLTU SHALL return 1 or 0, zero-extended.
REQ-017 Multi-cycle opcodes SHALL be: 10000 MUL (low half), 10001 MULH (s×s), 10010 MULHSU (s×u), 10011 MULHU (u×u), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
REQ-018 Any other opcode SHALL complete as a single-pass op with result 0, zero=1 and err=1; err SHALL be 0 for every legal opcode.
REQ-019 The FSM states SHALL be IDLE, MUL, DIV and DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where in_valid and in_ready are both 1, and operands and opcode SHALL be captured on that edge.
REQ-021 Single-pass ops accepted at cycle N SHALL present out_valid=1 at cycle N+1 (IDLE->DONE).
REQ-022 Multiply SHALL be iterative shift-add and divide SHALL be restoring, each one bit per cycle over XLEN cycles, using signed operands converted to magnitudes and sign-corrected at the end.
REQ-023 Multi-cycle ops accepted at cycle N SHALL present out_valid=1 at cycle N+XLEN+1 (IDLE->MUL/DIV->DONE), with the cycle counter loaded to XLEN-1 on accept.
REQ-024 For divide by zero, DIV/DIVU SHALL return all ones and REM/REMU SHALL return a, with the same latency as REQ-023 and err=0.
REQ-025 For signed overflow (a = most-negative value, b = -1), DIV SHALL return a and REM SHALL return 0.
REQ-026 In DONE, result, zero and err SHALL be held stable while out_ready=0; on out_ready=1 the FSM SHALL go DONE->IDLE, and in_ready SHALL be 1 on the next cycle (no same-cycle back-to-back).
REQ-027 flush=1 SHALL force IDLE on the next edge from any state and drop any in-flight or held result (out_valid=0); flush SHALL take priority over accept and over completion in the same cycle.
REQ-028 Input changes while not in IDLE SHALL have no effect on the pending result.

Reset
REQ-029 rst=1 SHALL immediately (asynchronously) force IDLE, out_valid=0, result=0, zero=1, err=0, and clear the counter and internal registers; this SHALL hold even mid-operation.
REQ-030 in_ready SHALL be 1 on the first clk edge after rst deasserts.

Verification (XLEN=32)
REQ-031 ADD of a=0xFFFFFFFF, b=1 -> result=0x00000000, zero=1, out_valid exactly 1 cycle after accept.
REQ-032 MULH of a=0x80000000, b=0x80000000 -> result=0x40000000; MULHU of a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE; both with out_valid at accept+33.
REQ-033 DIV of a=0x80000000, b=0xFFFFFFFF -> result=0x80000000; REM of a=-7, b=2 -> result=0xFFFFFFFF (-1); DIVU of a=5, b=0 -> result=0xFFFFFFFF.
REQ-034 SRA of a=0x80000000, b=0x00000021 -> result=0xC0000000 (shift amount 1); opcode 11111 -> result=0, err=1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; then out_ready=1 -> IDLE, and a new request is accepted the following cycle.
REQ-036 Assert rst at counter=10 of a DIVU, and flush at counter=5 of a MUL -> out_valid never asserts for either op; the next ADD 3+4 returns 7.

Source files
------------

// File: rtl/alu_mdu.sv
// ALU with iterative multiply/divide unit: single-pass logic/arith ops plus
// shift-add multiply and restoring divide, one bit per cycle, behind a valid/ready handshake.
module alu_mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            err
);
    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e              state_q, state_d;
    logic [1:0]          opsel_q, opsel_d;
    logic [SHW-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                err_q, err_d;

    logic [SHW-1:0]      shamt;
    logic                a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [XLEN-1:0]     sp_res;
    logic                sp_err;

    assign shamt = b[SHW-1:0];

    // Signedness of each operand: div group uses op[0] as "unsigned", mul group by sub-op
    always_comb begin
        a_sgn = alu_op[2] ? !alu_op[0] : (alu_op[1:0] == 2'b01 || alu_op[1:0] == 2'b10);
        b_sgn = alu_op[2] ? !alu_op[0] : (alu_op[1:0] == 2'b01);
        a_neg = a_sgn & a[XLEN-1];
        b_neg = b_sgn & b[XLEN-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
    end

    always_comb begin
        sp_res = '0;
        sp_err = 1'b0;
        case (alu_op)
            5'b00000: sp_res = a & b;
            5'b00001: sp_res = a | b;
            5'b00010: sp_res = a + b;
            5'b00110: sp_res = a - b;
            5'b00111: sp_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            5'b00100: sp_res = a ^ b;
            5'b00101: sp_res = a << shamt;
            5'b01000: sp_res = a >> shamt;
            5'b01001: sp_res = $signed(a) >>> shamt;
            5'b01010: sp_res = {{(XLEN-1){1'b0}}, a < b};
            default:  sp_err = 1'b1;
        endcase
    end

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, mul_prod;
    logic [XLEN-1:0]     mul_res;
    logic [XLEN:0]       rem_sh, diff;
    logic [2*XLEN-1:0]   div_next;
    logic [XLEN-1:0]     div_val, div_res;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mcand_q : {XLEN{1'b0}})};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        mul_prod = neg_q ? -mul_next : mul_next;
        mul_res  = (opsel_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        diff     = rem_sh - {1'b0, mcand_q};
        div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        div_val  = opsel_q[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        div_res  = neg_q ? -div_val : div_val;
    end

    always_comb begin
        state_d  = state_q;
        opsel_d  = opsel_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    opsel_d = alu_op[1:0];
                    err_d   = 1'b0;
                    if (alu_op[4:3] == 2'b10) begin
                        cnt_d   = SHW'(XLEN - 1);
                        mcand_d = alu_op[2] ? mag_b : mag_a;
                        acc_d   = {{XLEN{1'b0}}, (alu_op[2] ? mag_a : mag_b)};
                        // Divide-by-zero quotient stays all ones; remainder takes a's sign
                        if (alu_op[2]) begin
                            neg_d = alu_op[1] ? a_neg : ((a_neg ^ b_neg) && (b != '0));
                        end else begin
                            neg_d = a_neg ^ b_neg;
                        end
                        state_d = alu_op[2] ? StDiv : StMul;
                    end else begin
                        result_d = sp_res;
                        err_d    = sp_err;
                        state_d  = StDone;
                    end
                end
            end
            StMul, StDiv: begin
                acc_d = (state_q == StMul) ? mul_next : div_next;
                if (cnt_q == '0) begin
                    result_d = (state_q == StMul) ? mul_res : div_res;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            opsel_q  <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opsel_q  <= opsel_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign err       = err_q;

endmodule
